data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single-port data memory (15-bit address, 16-bit data, synchronous 1-cycle read) between the CPU data port and a secondary debug/loader port.
- The CPU has priority. A starvation counter forces a CPU stall so that a pending debug access completes within a bounded time.
- Sits between the CPU's outM/writeM/addressM/inM and the memory instance; the debug port is driven by a UART or switch-based loader.

Parameters:
- ADDR_W, 15, memory address width.
- DATA_W, 16, memory data width.
- STARVE_LIMIT, 4, consecutive blocked cycles of a pending debug request before the CPU is stalled (1..255).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset); deassertion synchronous to clk.
- cpu_addr  in  ADDR_W  CPU data address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_we  in  1  CPU write strobe.
- cpu_rdata  out  DATA_W  read data to CPU; equals mem_rdata.
- cpu_stall  out  1  CPU must hold its state (clock-enable low) this cycle.
- dbg_req  in  1  debug access request; held until dbg_gnt.
- dbg_we  in  1  debug write (1) / read (0); sampled with dbg_gnt.
- dbg_addr  in  ADDR_W  debug address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_gnt  out  1  one-cycle pulse; debug access issued this cycle.
- dbg_rvalid  out  1  one-cycle pulse; dbg_rdata valid.
- dbg_rdata  out  DATA_W  registered debug read data.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory read data (one cycle after address).

Behaviour:
- Reset values: dbg_gnt=0, dbg_rvalid=0, dbg_rdata=0, cpu_stall=0, starve_cnt=0, state=CPU_OWN.
- During reset the memory mux selects the CPU path with mem_we forced to 0.
- States:
  - CPU_OWN: mem_* = cpu_*.
    - dbg_req=1 and cpu_we=0: the debug access is issued opportunistically the same cycle. CPU reads are tolerated because cpu_stall=1 is raised that cycle.
    - Otherwise the debug request waits and starve_cnt increments.
    - When starve_cnt reaches STARVE_LIMIT, go to DBG_ISSUE.
  - DBG_ISSUE:
    - cpu_stall=1.
    - mem_addr=dbg_addr, mem_wdata=dbg_wdata, mem_we=dbg_we.
    - dbg_gnt=1; starve_cnt cleared.
    - Next state: DBG_READ if dbg_we=0, else CPU_OWN.
  - DBG_READ:
    - cpu_stall=1.
    - dbg_rdata<=mem_rdata; dbg_rvalid=1 the following cycle.
    - Return to CPU_OWN.
- Opportunistic issue in CPU_OWN with cpu_we=0 follows the same path as DBG_ISSUE: stall the CPU, pulse dbg_gnt, clear the counter.
  - Effective rule: a debug access is granted on the first cycle the CPU is not writing, or after STARVE_LIMIT blocked cycles, whichever comes first.
- CPU writes are never dropped. A CPU write in the same cycle as a starvation takeover is impossible because the takeover occurs only in the following cycle, after the write has committed.
- Debug latency: write = grant cycle; read = dbg_rvalid two cycles after dbg_gnt.
- dbg_req low while waiting clears starve_cnt and issues nothing.
- dbg_req held high after dbg_gnt is treated as a new request; back-to-back grants are allowed, with at least one CPU_OWN cycle between them.
- starve_cnt saturates and does not wrap.
- Reset asserted mid-access aborts it: no dbg_rvalid is produced and the state returns to CPU_OWN.
- cpu_rdata is always mem_rdata. The CPU ignores it while stalled.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: adds two outputs.
  - stat_grants (16 bit): counts dbg_gnt pulses.
  - stat_forced (16 bit): counts grants caused by the starvation limit.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset held low, random inputs -> mem_we=0, dbg_gnt=0, cpu_stall=0, dbg_rdata=0.
- cpu_we=0, dbg_req=1, dbg_we=1, dbg_addr=0x0010, dbg_wdata=0xBEEF -> same-cycle dbg_gnt=1, mem_we=1, mem_addr=0x0010, cpu_stall=1 for one cycle; a later CPU read of 0x0010 returns 0xBEEF.
- cpu_we=1 every cycle, dbg_req=1 read of 0x0010 -> dbg_gnt on cycle STARVE_LIMIT+1 (cycle 5), cpu_stall high 2 cycles, dbg_rvalid two cycles after grant with dbg_rdata=0xBEEF, no CPU write lost.
- CPU write 0x1234 to 0x0020 in the cycle before a forced grant -> memory holds 0x1234 and the debug read of 0x0020 returns 0x1234.
- reset pulled low during DBG_READ -> dbg_rvalid never asserts, state returns to CPU_OWN, dbg_rdata=0.
- With ARB_STATS_EN: 3 opportunistic grants plus 2 forced grants -> stat_grants=5, stat_forced=2.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: CPU, debug and memory bus of the data memory arbiter (ARB_STATS_EN adds stats outputs)
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
`ifdef ARB_STATS_EN
    logic [15:0]       stat_grants;
    logic [15:0]       stat_forced;
`endif

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
        output cpu_rdata, cpu_stall, dbg_gnt, dbg_rvalid, dbg_rdata, mem_addr, mem_wdata, mem_we
`ifdef ARB_STATS_EN
        , output stat_grants, stat_forced
`endif
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
        input  cpu_rdata, cpu_stall, dbg_gnt, dbg_rvalid, dbg_rdata, mem_addr, mem_wdata, mem_we
`ifdef ARB_STATS_EN
        , input stat_grants, stat_forced
`endif
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: CPU-priority sharing of the data memory with a debug port; ARB_STATS_EN adds grant counters
module data_mem_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input logic clk,
    input logic reset,
    data_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {CPU_OWN, DBG_ISSUE, DBG_READ} state_t;
    state_t     state, state_nx;
    logic [7:0] starve_cnt, starve_nx;
    logic       hold, gnt, stall, forced;

    // grant decision, next state and memory mux; reset parks the mux on the CPU with writes off
    always_comb begin
        state_nx      = state;
        starve_nx     = starve_cnt;
        gnt           = 1'b0;
        stall         = 1'b0;
        forced        = 1'b0;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_we    = bus.cpu_we;
        case (state)
            CPU_OWN: begin
                if (bus.dbg_req && !bus.cpu_we && !hold) begin
                    gnt       = 1'b1;
                    stall     = 1'b1;
                    starve_nx = 8'd0;
                    state_nx  = bus.dbg_we ? CPU_OWN : DBG_READ;
                end else if (bus.dbg_req) begin
                    starve_nx = (starve_cnt == 8'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 8'd1;
                    state_nx  = (starve_nx == 8'(STARVE_LIMIT)) ? DBG_ISSUE : CPU_OWN;
                end else begin
                    starve_nx = 8'd0;
                end
            end
            DBG_ISSUE: begin
                gnt       = 1'b1;
                stall     = 1'b1;
                forced    = 1'b1;
                starve_nx = 8'd0;
                state_nx  = bus.dbg_we ? CPU_OWN : DBG_READ;
            end
            DBG_READ: begin
                stall      = 1'b1;
                bus.mem_we = 1'b0;
                state_nx   = CPU_OWN;
            end
            default: state_nx = CPU_OWN;
        endcase
        if (gnt) begin
            bus.mem_addr  = bus.dbg_addr;
            bus.mem_wdata = bus.dbg_wdata;
            bus.mem_we    = bus.dbg_we;
        end
        if (!reset) begin
            gnt           = 1'b0;
            stall         = 1'b0;
            forced        = 1'b0;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_we    = 1'b0;
        end
    end

    assign bus.dbg_gnt   = gnt;
    assign bus.cpu_stall = stall;
    assign bus.cpu_rdata = bus.mem_rdata;

    // state, starvation count, one-cycle CPU slot after debug activity, and debug read capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= CPU_OWN;
            starve_cnt     <= 8'd0;
            hold           <= 1'b0;
            bus.dbg_rvalid <= 1'b0;
            bus.dbg_rdata  <= '0;
        end else begin
            state          <= state_nx;
            starve_cnt     <= starve_nx;
            hold           <= (gnt && bus.dbg_we) || state == DBG_READ;
            bus.dbg_rvalid <= state == DBG_READ;
            if (state == DBG_READ) bus.dbg_rdata <= bus.mem_rdata;
        end
    end

`ifdef ARB_STATS_EN
    // saturating counts of all grants and of starvation-forced grants
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.stat_grants <= 16'd0;
            bus.stat_forced <= 16'd0;
        end else begin
            if (gnt && bus.stat_grants != 16'hFFFF) bus.stat_grants <= bus.stat_grants + 16'd1;
            if (forced && bus.stat_forced != 16'hFFFF) bus.stat_forced <= bus.stat_forced + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed and randomized checks of data_mem_arbiter against a transaction-level model
module tb_data_mem_arbiter;
    localparam int AW    = 15;
    localparam int DW    = 16;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   passes = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // single-port synchronous memory behind the arbiter
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic cwe, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                         input logic dreq, input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dd);
        bus.cpu_we    = cwe;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
        bus.dbg_req   = dreq;
        bus.dbg_we    = dwe;
        bus.dbg_addr  = da;
        bus.dbg_wdata = dd;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 15'h7000, 16'h0, 1'b0, 1'b0, 15'h0, 16'h0);
    endtask

    task automatic cpu_read_chk(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        drive(1'b0, a, 16'h0, 1'b0, 1'b0, 15'h0, 16'h0);
        cyc();
        @(negedge clk);
        chk(tag, 32'(bus.cpu_rdata), 32'(exp));
        cyc();
    endtask

    // CPU writes every cycle while a debug read waits; grant is forced on cycle LIMIT+1
    task automatic forced_read(input logic [AW-1:0] da, input logic [AW-1:0] wbase,
                               input logic [AW-1:0] la, input logic [DW-1:0] ld,
                               input logic [DW-1:0] exp, input string tag);
        int i = 0;
        for (int c = 1; c <= 7; c++) begin
            drive(1'b1, (i == 3) ? la : wbase + AW'(i), (i == 3) ? ld : 16'hA000 + DW'(i),
                  c <= LIMIT + 1, 1'b0, da, 16'h0);
            @(negedge clk);
            chk({tag, "_gnt"}, 32'(bus.dbg_gnt), 32'(c == LIMIT + 1));
            chk({tag, "_stall"}, 32'(bus.cpu_stall), 32'(c == LIMIT + 1 || c == LIMIT + 2));
            chk({tag, "_rvalid"}, 32'(bus.dbg_rvalid), 32'(c == LIMIT + 3));
            if (c == LIMIT + 3) chk({tag, "_rdata"}, 32'(bus.dbg_rdata), 32'(exp));
            if (!(c == LIMIT + 1 || c == LIMIT + 2)) i++;
            cyc();
        end
        idle();
        cyc();
        for (int j = 0; j < 5; j++)
            cpu_read_chk((j == 3) ? la : wbase + AW'(j), (j == 3) ? ld : 16'hA000 + DW'(j), {tag, "_cpu_wr"});
    endtask

    logic [DW-1:0] rmem [16];
    logic [15:0]   known;

    initial begin
        logic          c_we, d_we, adv, pend, eg, ev, es, rd_known;
        logic [AW-1:0] c_a, d_a;
        logic [DW-1:0] c_d, d_d, pend_val, exp_rd;
        int            dst, gap, k, cnt;

        // reset held low with random inputs
        for (int n = 0; n < 4; n++) begin
            drive(1'($urandom), AW'($urandom), DW'($urandom), 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
            @(negedge clk);
            chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
            chk("rst_gnt", 32'(bus.dbg_gnt), 32'd0);
            chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
            chk("rst_rdata", 32'(bus.dbg_rdata), 32'd0);
            chk("rst_mux", 32'(bus.mem_addr), 32'(bus.cpu_addr));
            cyc();
        end

        // opportunistic debug write while the CPU reads
        reset = 1'b1;
        drive(1'b0, 15'h0100, 16'h0, 1'b1, 1'b1, 15'h0010, 16'hBEEF);
        @(negedge clk);
        chk("opp_gnt", 32'(bus.dbg_gnt), 32'd1);
        chk("opp_mem_we", 32'(bus.mem_we), 32'd1);
        chk("opp_mem_addr", 32'(bus.mem_addr), 32'h10);
        chk("opp_mem_wdata", 32'(bus.mem_wdata), 32'hBEEF);
        chk("opp_stall", 32'(bus.cpu_stall), 32'd1);
        cyc();
        idle();
        @(negedge clk);
        chk("opp_gnt_pulse", 32'(bus.dbg_gnt), 32'd0);
        chk("opp_stall_pulse", 32'(bus.cpu_stall), 32'd0);
        cyc();
        cpu_read_chk(15'h0010, 16'hBEEF, "opp_readback");

        forced_read(15'h0010, 15'h0300, 15'h0303, 16'hA003, 16'hBEEF, "frc");
        forced_read(15'h0020, 15'h0400, 15'h0020, 16'h1234, 16'h1234, "wbf");
        cpu_read_chk(15'h0020, 16'h1234, "wbf_cpu_read");

        // reset during DBG_READ aborts the read
        drive(1'b0, 15'h0100, 16'h0, 1'b1, 1'b0, 15'h0010, 16'h0);
        @(negedge clk);
        chk("abort_gnt", 32'(bus.dbg_gnt), 32'd1);
        cyc();
        reset = 1'b0;
        idle();
        @(negedge clk);
        chk("abort_stall", 32'(bus.cpu_stall), 32'd0);
        chk("abort_rdata", 32'(bus.dbg_rdata), 32'd0);
        for (int n = 0; n < 2; n++) begin
            cyc();
            @(negedge clk);
            chk("abort_rvalid_rst", 32'(bus.dbg_rvalid), 32'd0);
        end
        cyc();
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("abort_rvalid", 32'(bus.dbg_rvalid), 32'd0);
            chk("abort_stall_after", 32'(bus.cpu_stall), 32'd0);
            chk("abort_rdata_after", 32'(bus.dbg_rdata), 32'd0);
            cyc();
        end
        drive(1'b0, 15'h0100, 16'h0, 1'b1, 1'b1, 15'h0030, 16'h5555);
        @(negedge clk);
        chk("abort_cpu_own", 32'(bus.dbg_gnt), 32'd1);
        cyc();
        idle();
        cyc();

        // randomized traffic against a transaction-level model
        known = '0;
        dst = 0; gap = 2; k = 0; cnt = 0; adv = 1'b1; pend = 1'b0; rd_known = 1'b0;
        c_we = 1'b0; c_a = '0; c_d = '0; d_we = 1'b0; d_a = '0; d_d = '0; pend_val = '0; exp_rd = '0;
        for (int n = 0; n < 800; n++) begin
            if (adv) begin
                c_we = $urandom_range(0, 9) < 7;
                c_a  = 15'h0200 + AW'($urandom_range(0, 15));
                c_d  = DW'($urandom);
            end
            if (dst == 0 && gap == 0) begin
                dst  = 1;
                k    = 0;
                d_we = 1'($urandom_range(0, 1));
                d_a  = 15'h0200 + AW'($urandom_range(0, 15));
                d_d  = DW'($urandom);
            end
            drive(c_we, c_a, c_d, dst == 1, d_we, d_a, d_d);
            @(negedge clk);
            eg = dst == 1 && ((k < LIMIT && !c_we) || k == LIMIT);
            ev = dst == 2 && cnt == 2;
            es = eg || (dst == 2 && cnt == 1);
            chk("rnd_gnt", 32'(bus.dbg_gnt), 32'(eg));
            chk("rnd_stall", 32'(bus.cpu_stall), 32'(es));
            chk("rnd_rvalid", 32'(bus.dbg_rvalid), 32'(ev));
            if (ev && rd_known) chk("rnd_dbg_rdata", 32'(bus.dbg_rdata), 32'(exp_rd));
            if (pend) chk("rnd_cpu_rdata", 32'(bus.cpu_rdata), 32'(pend_val));
            pend     = !es && !c_we && known[c_a[3:0]];
            pend_val = rmem[c_a[3:0]];
            if (!es && c_we) begin
                rmem[c_a[3:0]]  = c_d;
                known[c_a[3:0]] = 1'b1;
            end
            if (eg) begin
                if (d_we) begin
                    rmem[d_a[3:0]]  = d_d;
                    known[d_a[3:0]] = 1'b1;
                    dst = 0;
                    gap = $urandom_range(1, 3);
                end else begin
                    rd_known = known[d_a[3:0]];
                    exp_rd   = rmem[d_a[3:0]];
                    dst = 2;
                    cnt = 1;
                end
            end else if (dst == 1) begin
                k++;
            end else if (dst == 2) begin
                if (cnt == 2) begin
                    dst = 0;
                    gap = $urandom_range(1, 3);
                end else cnt++;
            end else if (gap > 0) begin
                gap--;
            end
            adv = !es;
            cyc();
        end

        // fresh reset, then three opportunistic and two forced grants
        idle();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        for (int j = 0; j < 3; j++) begin
            drive(1'b0, 15'h0100, 16'h0, 1'b1, 1'b1, 15'h0500 + AW'(j), DW'(j));
            @(negedge clk);
            chk("stat_opp_gnt", 32'(bus.dbg_gnt), 32'd1);
            cyc();
            idle();
            cyc();
        end
        forced_read(15'h0500, 15'h0600, 15'h0603, 16'hA003, 16'h0000, "st1");
        forced_read(15'h0502, 15'h0700, 15'h0703, 16'hA003, 16'h0002, "st2");
`ifdef ARB_STATS_EN
        chk("stat_grants", 32'(bus.stat_grants), 32'd5);
        chk("stat_forced", 32'(bus.stat_forced), 32'd2);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
